// File: rtl/serial_matmul_mem_arb.sv
// rtl/serial_matmul_mem_arb.sv - two-requester memory port arbiter with in-order response steering
//
// Shares one memory request/response port between req0 (operand loader) and
// req1 (result write-back). Requests are granted round-robin and passed
// through combinationally. An owner FIFO records the requester of each
// accepted request so that in-order responses can be steered back to it.
//
// Optional feature macro: SERIAL_MATMUL_ARB_PRIO_EN
//   defined   -> fixed priority, req0 wins any contention
//   undefined -> round-robin between the two requesters
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   reqN_*                requester N (N=0,1) request channel, valid/ready
//   mem_req_*             muxed request toward memory, valid/ready
//   mem_resp_*            memory response (no back-pressure)
//   respN_valid_o         response belongs to requester N
//   resp_*_o              shared response fields, copy of mem_resp_*
//   outstanding_o         owner-FIFO occupancy
//   err_o                 sticky: response arrived with no outstanding request

module serial_matmul_mem_arb #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_NBITS      = 40,
    parameter int DATA_NBITS      = 64
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic                                 req0_valid_i,
    output logic                                 req0_ready_o,
    input  logic [4:0]                           req0_cmd_i,
    input  logic [2:0]                           req0_typ_i,
    input  logic [ADDR_NBITS-1:0]                req0_addr_i,
    input  logic [DATA_NBITS-1:0]                req0_data_i,

    input  logic                                 req1_valid_i,
    output logic                                 req1_ready_o,
    input  logic [4:0]                           req1_cmd_i,
    input  logic [2:0]                           req1_typ_i,
    input  logic [ADDR_NBITS-1:0]                req1_addr_i,
    input  logic [DATA_NBITS-1:0]                req1_data_i,

    output logic                                 mem_req_valid_o,
    input  logic                                 mem_req_ready_i,
    output logic [4:0]                           mem_req_cmd_o,
    output logic [2:0]                           mem_req_typ_o,
    output logic [ADDR_NBITS-1:0]                mem_req_addr_o,
    output logic [DATA_NBITS-1:0]                mem_req_data_o,

    input  logic                                 mem_resp_valid_i,
    input  logic [4:0]                           mem_resp_cmd_i,
    input  logic [2:0]                           mem_resp_typ_i,
    input  logic [ADDR_NBITS-1:0]                mem_resp_addr_i,
    input  logic [DATA_NBITS-1:0]                mem_resp_data_i,

    output logic                                 resp0_valid_o,
    output logic                                 resp1_valid_o,
    output logic [4:0]                           resp_cmd_o,
    output logic [2:0]                           resp_typ_o,
    output logic [ADDR_NBITS-1:0]                resp_addr_o,
    output logic [DATA_NBITS-1:0]                resp_data_o,

    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
    output logic                                 err_o
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    logic                       lock_q, lock_d;
    logic                       lock_id_q, lock_id_d;
    logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       err_q, err_d;

    logic full, empty;
    logic gnt_valid, gnt_id;
    logic contend_id;
    logic sel1;
    logic push, pop, head;

    assign full  = (count_q == CW'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);

`ifdef SERIAL_MATMUL_ARB_PRIO_EN
    assign contend_id = 1'b0;
`else
    logic rr_last_q, rr_last_d;

    // Contention goes to whoever did not win last.
    assign contend_id = ~rr_last_q;
    assign rr_last_d  = push ? gnt_id : rr_last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    // Grant selection. A locked grant keeps a stalled request stable until
    // memory accepts it; a full FIFO blocks every grant.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (!full) begin
            if (lock_q) begin
                gnt_valid = 1'b1;
                gnt_id    = lock_id_q;
            end else if (req0_valid_i && req1_valid_i) begin
                gnt_valid = 1'b1;
                gnt_id    = contend_id;
            end else if (req0_valid_i) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (req1_valid_i) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    assign sel1            = gnt_valid & gnt_id;
    assign mem_req_valid_o = gnt_valid & (gnt_id ? req1_valid_i : req0_valid_i);
    assign mem_req_cmd_o   = sel1 ? req1_cmd_i  : req0_cmd_i;
    assign mem_req_typ_o   = sel1 ? req1_typ_i  : req0_typ_i;
    assign mem_req_addr_o  = sel1 ? req1_addr_i : req0_addr_i;
    assign mem_req_data_o  = sel1 ? req1_data_i : req0_data_i;

    // gnt_valid already implies !full.
    assign req0_ready_o = gnt_valid & ~gnt_id & mem_req_ready_i;
    assign req1_ready_o = gnt_valid &  gnt_id & mem_req_ready_i;

    assign push = mem_req_valid_o & mem_req_ready_i;
    assign pop  = mem_resp_valid_i & ~empty;
    assign head = owner_q[rd_ptr_q];

    assign resp0_valid_o = pop & ~head;
    assign resp1_valid_o = pop &  head;
    assign resp_cmd_o    = mem_resp_cmd_i;
    assign resp_typ_o    = mem_resp_typ_i;
    assign resp_addr_o   = mem_resp_addr_i;
    assign resp_data_o   = mem_resp_data_i;

    assign outstanding_o = count_q;
    assign err_o         = err_q;

    always_comb begin
        // Lock only while a presented request is stalled; a dropped valid or
        // an accepted request both release it.
        lock_d    = mem_req_valid_o & ~mem_req_ready_i;
        lock_id_d = lock_d ? gnt_id : lock_id_q;

        owner_d  = owner_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | (mem_resp_valid_i & empty);

        if (push) begin
            owner_d[wr_ptr_q] = gnt_id;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            owner_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            owner_q   <= owner_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

endmodule
